// File: rtl/instr_encoder.sv
// RV32I program loader: accepts instruction-field requests, validates and encodes them,
// then writes the machine words to sequential word-aligned addresses with an ack handshake.
module instr_encoder #(
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned MAX_WORDS = 1024,
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  word_count,
    output logic              full,
    output logic              err_valid,
    output logic [2:0]        err_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_ERR
    } state_e;

    typedef enum logic [3:0] {
        K_R      = 4'd0,
        K_IALU   = 4'd1,
        K_ISHIFT = 4'd2,
        K_LOAD   = 4'd3,
        K_STORE  = 4'd4,
        K_BRANCH = 4'd5,
        K_LUI    = 4'd6,
        K_AUIPC  = 4'd7,
        K_JAL    = 4'd8,
        K_JALR   = 4'd9
    } kind_e;

    typedef enum logic [2:0] {
        E_NONE   = 3'd0,
        E_KIND   = 3'd1,
        E_FUNCT3 = 3'd2,
        E_ALT    = 3'd3,
        E_RANGE  = 3'd4,
        E_ALIGN  = 3'd5
    } err_e;

    state_e      state;
    state_e      state_next;
    err_e        chk;

    logic [3:0]  c_kind;
    logic [2:0]  c_funct3;
    logic        c_alt;
    logic [4:0]  c_rd;
    logic [4:0]  c_rs1;
    logic [4:0]  c_rs2;
    logic [31:0] c_imm;

    // First failing rule wins: kind, funct3, alt, immediate range, immediate alignment.
    function automatic err_e check_fields(input logic [3:0] kind, input logic [2:0] f3,
                                          input logic alt, input logic [31:0] imm);
        logic signed [31:0] s;
        logic               f3_bad;
        logic               alt_ok;
        logic               rng_bad;
        logic               align_bad;
        s         = imm;
        alt_ok    = ((kind == K_R) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                    ((kind == K_ISHIFT) && (f3 == 3'b101));
        align_bad = ((kind == K_BRANCH) || (kind == K_JAL)) && imm[0];
        case (kind)
            K_BRANCH: f3_bad = (f3 == 3'b010) || (f3 == 3'b011);
            K_LOAD:   f3_bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            K_STORE:  f3_bad = (f3 > 3'b010);
            K_JALR:   f3_bad = (f3 != 3'b000);
            K_ISHIFT: f3_bad = (f3 != 3'b001) && (f3 != 3'b101);
            default:  f3_bad = 1'b0;
        endcase
        case (kind)
            K_IALU, K_LOAD, K_STORE, K_JALR:
                rng_bad = (s < -32'sd2048) || (s > 32'sd2047);
            K_ISHIFT: rng_bad = (imm > 32'd31);
            K_BRANCH: rng_bad = (s < -32'sd4096) || (s > 32'sd4094);
            K_JAL:    rng_bad = (s < -32'sd1048576) || (s > 32'sd1048574);
            K_LUI, K_AUIPC: rng_bad = (imm[11:0] != 12'd0);
            default:  rng_bad = 1'b0;
        endcase
        if (kind > 4'd9)
            check_fields = E_KIND;
        else if (f3_bad)
            check_fields = E_FUNCT3;
        else if (alt && !alt_ok)
            check_fields = E_ALT;
        else if (rng_bad)
            check_fields = E_RANGE;
        else if (align_bad)
            check_fields = E_ALIGN;
        else
            check_fields = E_NONE;
    endfunction

    function automatic logic [31:0] encode(input logic [3:0] kind, input logic [2:0] f3,
                                           input logic alt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [6:0] f7;
        f7 = alt ? 7'b0100000 : 7'b0000000;
        case (kind)
            K_R:      encode = {f7, rs2, rs1, f3, rd, 7'b0110011};
            K_IALU:   encode = {imm[11:0], rs1, f3, rd, 7'b0010011};
            K_ISHIFT: encode = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
            K_LOAD:   encode = {imm[11:0], rs1, f3, rd, 7'b0000011};
            K_STORE:  encode = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            K_BRANCH: encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            K_LUI:    encode = {imm[31:12], rd, 7'b0110111};
            K_AUIPC:  encode = {imm[31:12], rd, 7'b0010111};
            K_JAL:    encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            K_JALR:   encode = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            default:  encode = '0;
        endcase
    endfunction

    assign chk       = check_fields(c_kind, c_funct3, c_alt, c_imm);
    assign full      = (word_count == CNT_W'(MAX_WORDS));
    assign in_ready  = (state == S_IDLE) && !full;
    assign mem_we    = (state == S_WRITE);
    assign err_valid = (state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid && in_ready) state_next = S_CHECK;
            S_CHECK: state_next = (chk == E_NONE) ? S_WRITE : S_ERR;
            S_WRITE: if (mem_ack) state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // load_base and capture share the IDLE edge, so a same-cycle request writes at the new base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_kind     <= '0;
            c_funct3   <= '0;
            c_alt      <= 1'b0;
            c_rd       <= '0;
            c_rs1      <= '0;
            c_rs2      <= '0;
            c_imm      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            err_code   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_base) begin
                        mem_addr   <= {base_addr[ADDR_W-1:2], 2'b00};
                        word_count <= '0;
                    end
                    if (in_valid && in_ready) begin
                        c_kind   <= in_kind;
                        c_funct3 <= in_funct3;
                        c_alt    <= in_alt;
                        c_rd     <= in_rd;
                        c_rs1    <= in_rs1;
                        c_rs2    <= in_rs2;
                        c_imm    <= in_imm;
                    end
                end
                S_CHECK: begin
                    if (chk == E_NONE)
                        mem_wdata <= encode(c_kind, c_funct3, c_alt, c_rd, c_rs1, c_rs2, c_imm);
                    else
                        err_code <= chk;
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_addr   <= mem_addr + ADDR_W'(4);
                        word_count <= word_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
